cache_line_store_merge: RTL and testbench



---
 rtl/cache_line_store_merge.sv | 116 +++++++++++
 tb/tb_cache_line_store_merge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_store_merge.sv
// Store-merge engine for the 2-way cache write path. Reads the target line
// from both way arrays, splices the enabled bytes of one 16-bit store word
// into the selected way's line, writes it back, then pulses completion.
module cache_line_store_merge #(
  parameter int INDEX_BITS = 3,
  parameter int LINE_BITS  = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_way,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic [3:0]            req_offset,
  input  logic [15:0]           req_wdata,
  input  logic [1:0]            req_byte_en,
  output logic                  arr_read,
  output logic [INDEX_BITS-1:0] arr_index,
  input  logic [LINE_BITS-1:0]  arr_rdata0,
  input  logic [LINE_BITS-1:0]  arr_rdata1,
  output logic                  arr_we0,
  output logic                  arr_we1,
  output logic [LINE_BITS-1:0]  arr_wdata,
  output logic                  resp_valid
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_way;
  logic [INDEX_BITS-1:0] r_index;
  logic [2:0]            r_word;
  logic [15:0]           r_wdata;
  logic [1:0]            r_byte_en;
  logic [LINE_BITS-1:0]  r_line;
  logic [LINE_BITS-1:0]  w_merged;
  logic [6:0]            w_lo_base;
  logic [6:0]            w_hi_base;
  logic                  w_unused;

  // Byte address bit 0 has no meaning for a word store; it is dropped here.
  assign w_unused  = req_offset[0];
  assign w_lo_base = {r_word, 4'b0000};
  assign w_hi_base = {r_word, 4'b1000};

  // State register; reset abandons any in-flight store immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Capture the request only when accepted in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_way     <= 1'b0;
      r_index   <= '0;
      r_word    <= '0;
      r_wdata   <= '0;
      r_byte_en <= '0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_way     <= req_way;
      r_index   <= req_index;
      r_word    <= req_offset[3:1];
      r_wdata   <= req_wdata;
      r_byte_en <= req_byte_en;
    end
  end

  // Merge the store bytes over the selected way's line as it returns.
  always_comb begin
    w_merged = r_way ? arr_rdata1 : arr_rdata0;
    if (r_byte_en[0]) w_merged[w_lo_base +: 8] = r_wdata[7:0];
    if (r_byte_en[1]) w_merged[w_hi_base +: 8] = r_wdata[15:8];
  end

  // Line register holds the merged line for the write cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_line <= '0;
    else if (r_state == S_MERGE) r_line <= w_merged;
  end

  assign arr_index = r_index;
  assign arr_wdata = r_line;

  // Next-state and strobe decode; a zero byte mask skips the write.
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    arr_read   = 1'b0;
    arr_we0    = 1'b0;
    arr_we1    = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_READ;
      end
      S_READ: begin
        arr_read = 1'b1;
        w_next   = S_MERGE;
      end
      S_MERGE: w_next = (r_byte_en == 2'b00) ? S_RESP : S_WRITE;
      S_WRITE: begin
        arr_we0 = ~r_way;
        arr_we1 = r_way;
        w_next  = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_line_store_merge.sv
// Directed bench for the store-merge engine: the bench plays both way arrays
// by holding arr_rdata0/1 at a chosen line and checks strobes cycle by cycle.
module tb_cache_line_store_merge;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         req_valid;
  logic         req_ready;
  logic         req_way;
  logic [2:0]   req_index;
  logic [3:0]   req_offset;
  logic [15:0]  req_wdata;
  logic [1:0]   req_byte_en;
  logic         arr_read;
  logic [2:0]   arr_index;
  logic [127:0] arr_rdata0;
  logic [127:0] arr_rdata1;
  logic         arr_we0;
  logic         arr_we1;
  logic [127:0] arr_wdata;
  logic         resp_valid;

  int total = 0;
  int bad   = 0;

  // Per-cycle trace; index k is cycle N+k after acceptance edge N.
  logic         tr_read  [1:16];
  logic         tr_we0   [1:16];
  logic         tr_we1   [1:16];
  logic         tr_resp  [1:16];
  logic         tr_ready [1:16];
  logic [2:0]   tr_idx   [1:16];
  logic [127:0] tr_wdata [1:16];

  always #5 clk = ~clk;

  cache_line_store_merge #(.INDEX_BITS(3), .LINE_BITS(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_way(req_way),
    .req_index(req_index), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en),
    .arr_read(arr_read), .arr_index(arr_index),
    .arr_rdata0(arr_rdata0), .arr_rdata1(arr_rdata1),
    .arr_we0(arr_we0), .arr_we1(arr_we1), .arr_wdata(arr_wdata),
    .resp_valid(resp_valid)
  );

  task automatic rec(input int k);
    tr_read[k]  = arr_read;
    tr_we0[k]   = arr_we0;
    tr_we1[k]   = arr_we1;
    tr_resp[k]  = resp_valid;
    tr_ready[k] = req_ready;
    tr_idx[k]   = arr_index;
    tr_wdata[k] = arr_wdata;
  endtask

  // Present one request for a single edge, then record n cycles.
  task automatic issue(input logic way, input logic [2:0] idx, input logic [3:0] off,
                       input logic [15:0] wd, input logic [1:0] be, input int n);
    @(negedge clk);
    req_way = way; req_index = idx; req_offset = off; req_wdata = wd; req_byte_en = be;
    req_valid = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      rec(k);
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    total++; if (arr_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", arr_read); end
    total++; if ({arr_we1, arr_we0} !== 2'b00) begin bad++; $display("FAIL rst_we got=%b exp=00", {arr_we1, arr_we0}); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0", resp_valid); end
    total++; if (arr_index !== 3'd0) begin bad++; $display("FAIL rst_index got=%0d exp=0", arr_index); end
    total++; if (arr_wdata !== 128'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", arr_wdata); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Offset 6 -> word 3 -> bits [63:48].
  task automatic test_way0_full;
    logic [127:0] exp;
    exp = 128'h0000_0000_0000_0000_BEEF_0000_0000_0000;
    arr_rdata0 = 128'h0;
    arr_rdata1 = {128{1'b1}};
    issue(1'b0, 3'd3, 4'h6, 16'hBEEF, 2'b11, 5);
    total++; if (tr_read[1] !== 1'b1) begin bad++; $display("FAIL w0_read_n1 got=%b exp=1", tr_read[1]); end
    total++; if (tr_idx[1] !== 3'd3) begin bad++; $display("FAIL w0_idx_n1 got=%0d exp=3", tr_idx[1]); end
    total++; if (tr_read[2] !== 1'b0) begin bad++; $display("FAIL w0_read_n2 got=%b exp=0", tr_read[2]); end
    total++; if (tr_we0[2] !== 1'b0) begin bad++; $display("FAIL w0_we0_n2 got=%b exp=0", tr_we0[2]); end
    total++; if (tr_we0[3] !== 1'b1) begin bad++; $display("FAIL w0_we0_n3 got=%b exp=1", tr_we0[3]); end
    total++; if (tr_we1[3] !== 1'b0) begin bad++; $display("FAIL w0_we1_n3 got=%b exp=0", tr_we1[3]); end
    total++; if (tr_wdata[3] !== exp) begin bad++; $display("FAIL w0_wdata got=%h exp=%h", tr_wdata[3], exp); end
    total++; if (tr_idx[3] !== 3'd3) begin bad++; $display("FAIL w0_idx_n3 got=%0d exp=3", tr_idx[3]); end
    total++; if (tr_resp[3] !== 1'b0) begin bad++; $display("FAIL w0_resp_n3 got=%b exp=0", tr_resp[3]); end
    total++; if (tr_resp[4] !== 1'b1) begin bad++; $display("FAIL w0_resp_n4 got=%b exp=1", tr_resp[4]); end
    total++; if (tr_ready[4] !== 1'b0) begin bad++; $display("FAIL w0_ready_n4 got=%b exp=0", tr_ready[4]); end
    total++; if (tr_ready[5] !== 1'b1) begin bad++; $display("FAIL w0_ready_n5 got=%b exp=1", tr_ready[5]); end
  endtask

  task automatic test_way1_high_byte;
    logic [127:0] exp;
    exp = {16'hAB11, {7{16'h1111}}};
    arr_rdata0 = 128'h0;
    arr_rdata1 = {8{16'h1111}};
    issue(1'b1, 3'd5, 4'hE, 16'hAB00, 2'b10, 5);
    total++; if (tr_we1[3] !== 1'b1) begin bad++; $display("FAIL w1_we1 got=%b exp=1", tr_we1[3]); end
    total++; if (tr_we0[3] !== 1'b0) begin bad++; $display("FAIL w1_we0 got=%b exp=0", tr_we0[3]); end
    total++; if (tr_wdata[3] !== exp) begin bad++; $display("FAIL w1_wdata got=%h exp=%h", tr_wdata[3], exp); end
    total++; if (tr_idx[3] !== 3'd5) begin bad++; $display("FAIL w1_idx got=%0d exp=5", tr_idx[3]); end
    total++; if (tr_resp[4] !== 1'b1) begin bad++; $display("FAIL w1_resp got=%b exp=1", tr_resp[4]); end
  endtask

  task automatic test_offset_bit0;
    logic [127:0] exp;
    exp = {{7{16'hFFFF}}, 16'hFFCD};
    arr_rdata0 = {128{1'b1}};
    arr_rdata1 = 128'h0;
    issue(1'b0, 3'd2, 4'h1, 16'h00CD, 2'b01, 5);
    total++; if (tr_we0[3] !== 1'b1) begin bad++; $display("FAIL ob_we0 got=%b exp=1", tr_we0[3]); end
    total++; if (tr_wdata[3] !== exp) begin bad++; $display("FAIL ob_wdata got=%h exp=%h", tr_wdata[3], exp); end
  endtask

  task automatic test_no_byte_en;
    logic any_we;
    arr_rdata0 = 128'h0;
    arr_rdata1 = {8{16'h2222}};
    issue(1'b1, 3'd4, 4'h0, 16'h1234, 2'b00, 5);
    any_we = 1'b0;
    for (int k = 1; k <= 5; k++) any_we = any_we | tr_we0[k] | tr_we1[k];
    total++; if (tr_read[1] !== 1'b1) begin bad++; $display("FAIL nb_read got=%b exp=1", tr_read[1]); end
    total++; if (any_we !== 1'b0) begin bad++; $display("FAIL nb_any_we got=%b exp=0", any_we); end
    total++; if (tr_resp[3] !== 1'b1) begin bad++; $display("FAIL nb_resp_n3 got=%b exp=1", tr_resp[3]); end
    total++; if (tr_resp[4] !== 1'b0) begin bad++; $display("FAIL nb_resp_n4 got=%b exp=0", tr_resp[4]); end
    total++; if (tr_ready[4] !== 1'b1) begin bad++; $display("FAIL nb_ready_n4 got=%b exp=1", tr_ready[4]); end
  endtask

  task automatic test_reset_mid_write;
    logic seen;
    arr_rdata0 = {8{16'h5555}};
    arr_rdata1 = 128'h0;
    @(negedge clk);
    req_way = 1'b0; req_index = 3'd6; req_offset = 4'h0; req_wdata = 16'hFFFF; req_byte_en = 2'b11;
    req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (arr_we0 !== 1'b1) begin bad++; $display("FAIL rm_we0_before got=%b exp=1", arr_we0); end
    #1 reset_n = 1'b0;
    #1;
    total++; if ({arr_we1, arr_we0} !== 2'b00) begin bad++; $display("FAIL rm_we_after got=%b exp=00", {arr_we1, arr_we0}); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_in_rst got=%b exp=1", req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen = seen | resp_valid | arr_we0 | arr_we1 | arr_read;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_activity got=%b exp=0", seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after got=%b exp=1", req_ready); end
  endtask

  // req_valid held high: second accept waits for the IDLE cycle after RESP.
  task automatic test_back_to_back;
    logic [127:0] exp_a, exp_b;
    exp_a = 128'h0000_0000_0000_1234_0000_0000_0000_0000;
    exp_b = 128'h0000_0000_0000_0000_0000_0000_0000_5A5A;
    arr_rdata0 = 128'h0;
    arr_rdata1 = 128'h0;
    @(negedge clk);
    req_way = 1'b0; req_index = 3'd1; req_offset = 4'h8; req_wdata = 16'h1234; req_byte_en = 2'b11;
    req_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_way = 1'b1; req_index = 3'd7; req_offset = 4'h0; req_wdata = 16'h5A5A; req_byte_en = 2'b11;
      end
      if (k == 6) req_valid = 1'b0;
      rec(k);
    end
    total++; if (tr_we0[3] !== 1'b1) begin bad++; $display("FAIL bb_a_we0 got=%b exp=1", tr_we0[3]); end
    total++; if (tr_wdata[3] !== exp_a) begin bad++; $display("FAIL bb_a_wdata got=%h exp=%h", tr_wdata[3], exp_a); end
    total++; if (tr_resp[4] !== 1'b1) begin bad++; $display("FAIL bb_a_resp got=%b exp=1", tr_resp[4]); end
    total++; if (tr_read[5] !== 1'b0) begin bad++; $display("FAIL bb_read_n5 got=%b exp=0", tr_read[5]); end
    total++; if (tr_ready[5] !== 1'b1) begin bad++; $display("FAIL bb_ready_n5 got=%b exp=1", tr_ready[5]); end
    total++; if (tr_read[6] !== 1'b1) begin bad++; $display("FAIL bb_read_n6 got=%b exp=1", tr_read[6]); end
    total++; if (tr_idx[6] !== 3'd7) begin bad++; $display("FAIL bb_idx_n6 got=%0d exp=7", tr_idx[6]); end
    total++; if ({tr_we1[8], tr_we0[8]} !== 2'b10) begin bad++; $display("FAIL bb_b_we got=%b exp=10", {tr_we1[8], tr_we0[8]}); end
    total++; if (tr_wdata[8] !== exp_b) begin bad++; $display("FAIL bb_b_wdata got=%h exp=%h", tr_wdata[8], exp_b); end
    total++; if (tr_resp[9] !== 1'b1) begin bad++; $display("FAIL bb_b_resp got=%b exp=1", tr_resp[9]); end
    total++; if (tr_read[11] !== 1'b0) begin bad++; $display("FAIL bb_no_third got=%b exp=0", tr_read[11]); end
  endtask

  initial begin
    req_valid = 1'b0; req_way = 1'b0; req_index = '0; req_offset = '0;
    req_wdata = '0; req_byte_en = '0;
    arr_rdata0 = '0; arr_rdata1 = '0;
    test_reset;
    test_way0_full;
    test_way1_high_byte;
    test_offset_bit0;
    test_no_byte_en;
    test_reset_mid_write;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
